// File: rtl/shift_sched.sv
// Round-robin scheduler that feeds a registered 2-bit shifter,
// splitting each shift amount into passes and looping results back.
module shift_sched #(
  parameter int DATA_W   = 8,
  parameter int AMT_W    = 3,
  parameter int PASS_MAX = 3,
  parameter int SH_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              busy,
  output logic [SH_W-1:0]   sh_shift,
  output logic [DATA_W-1:0] sh_d,
  input  logic [DATA_W-1:0] sh_q
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [AMT_W-1:0] PMAX = AMT_W'(PASS_MAX);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic [AMT_W-1:0]  rem;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic [AMT_W-1:0]  acc_step;
  logic [AMT_W-1:0]  rem_step;

  // Arbitration: lone requester wins, otherwise alternate away from last_grant
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == IDLE) && !rst && grant0;
    req1_ready = (state == IDLE) && !rst && grant1;
    accept     = req0_ready || req1_ready;
    sel_data   = grant1 ? req1_data : req0_data;
    sel_amt    = grant1 ? req1_amt : req0_amt;
    acc_step   = (sel_amt > PMAX) ? PMAX : sel_amt;
    rem_step   = (rem > PMAX) ? PMAX : rem;
    busy       = (state != IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  state_nxt = (rem == '0) ? DONE : ISSUE;
      DONE:  if (out_ready) state_nxt = IDLE;
    endcase
  end

  // Datapath: latch job, chain passes through the shifter, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      rem        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= 1'b0;
      sh_shift   <= '0;
      sh_d       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          out_id     <= grant1;
          last_grant <= grant1;
          sh_d       <= sel_data;
          sh_shift   <= SH_W'(acc_step);
          rem        <= sel_amt - acc_step;
        end
        WAIT: if (rem == '0) begin
          out_data  <= sh_q;
          out_valid <= 1'b1;
        end else begin
          sh_d     <= sh_q;
          sh_shift <= SH_W'(rem_step);
          rem      <= rem - rem_step;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched with a registered shifter model,
// covering latency, pass splitting, arbitration, back-pressure and reset.
module tb_shift_sched;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic [2:0] req1_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_id;
  logic       busy;
  logic [1:0] sh_shift;
  logic [7:0] sh_d;
  logic [7:0] sh_q;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_amt(req1_amt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .busy(busy),
    .sh_shift(sh_shift), .sh_d(sh_d), .sh_q(sh_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 8-bit left shifter, one cycle latency
  initial sh_q = 8'h00;
  always @(posedge clk) sh_q <= sh_d << sh_shift;

  // Runs one job from an idle DUT; stops at the first out_valid cycle
  task automatic do_job(input logic id, input logic [7:0] d,
                        input logic [2:0] a, output int lat,
                        output logic [11:0] seq, output logic [7:0] q,
                        output logic qid, output logic [1:0] rdy);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a;
    end
    #1 rdy = {req1_ready, req0_ready};
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    seq = {10'd0, sh_shift};
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (lat % 2 == 0) seq = {seq[9:0], sh_shift};
    end
    q   = out_data;
    qid = out_id;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, out_id, sh_shift, sh_d, busy,
         req0_ready, req1_ready} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b od=%h id=%b sh=%0d d=%h busy=%b r=%b%b, expected all 0",
               out_valid, out_data, out_id, sh_shift, sh_d, busy,
               req1_ready, req0_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [11:0] seq; logic [7:0] q; logic qid; logic [1:0] rdy;
    do_job(1'b0, 8'h01, 3'd2, lat, seq, q, qid, rdy);
    n_checks++;
    if (rdy !== 2'b01) begin
      n_fail++; $display("FAIL t1_ready: got %b expected 01", rdy);
    end
    n_checks++;
    if (q !== 8'h04 || qid !== 1'b0) begin
      n_fail++; $display("FAIL t1_result: got %h/%b expected 04/0", q, qid);
    end
    n_checks++;
    if (lat !== 2 || seq !== 12'h002) begin
      n_fail++; $display("FAIL t1_latency: got lat=%0d seq=%h expected 2/002", lat, seq);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL t1_busy_done: got %b expected 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t1_release: got ov=%b busy=%b expected 0/0", out_valid, busy);
    end
  endtask

  task automatic test_multipass();
    int lat; logic [11:0] seq; logic [7:0] q; logic qid; logic [1:0] rdy;
    do_job(1'b1, 8'h01, 3'd7, lat, seq, q, qid, rdy);
    n_checks++;
    if (rdy !== 2'b10 || q !== 8'h80 || qid !== 1'b1) begin
      n_fail++; $display("FAIL t2_result: got rdy=%b q=%h id=%b expected 10/80/1", rdy, q, qid);
    end
    n_checks++;
    if (lat !== 6 || seq !== 12'h03D) begin
      n_fail++; $display("FAIL t2_passes: got lat=%0d seq=%h expected 6/03d", lat, seq);
    end
    @(negedge clk);
  endtask

  task automatic test_edges();
    int lat; logic [11:0] seq; logic [7:0] q; logic qid; logic [1:0] rdy;
    do_job(1'b0, 8'hFF, 3'd5, lat, seq, q, qid, rdy);
    n_checks++;
    if (q !== 8'hE0 || lat !== 4 || seq !== 12'h00E) begin
      n_fail++; $display("FAIL t3_amt5: got q=%h lat=%0d seq=%h expected e0/4/00e", q, lat, seq);
    end
    @(negedge clk);
    do_job(1'b1, 8'hA5, 3'd0, lat, seq, q, qid, rdy);
    n_checks++;
    if (q !== 8'hA5 || lat !== 2 || seq !== 12'h000 || qid !== 1'b1) begin
      n_fail++; $display("FAIL t3_amt0: got q=%h lat=%0d seq=%h id=%b expected a5/2/000/1", q, lat, seq, qid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int n_out = 0;
    int perr  = 0;
    logic [1:0] prev = 2'b00;
    logic [1:0] r;
    logic [2:0] acc_ids = 3'b000;
    logic [2:0] out_ids = 3'b000;
    logic [23:0] outs = 24'd0;
    logic drop = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h03; req0_amt = 3'd1;
    req1_valid = 1'b1; req1_data = 8'h10; req1_amt = 3'd3;
    for (int i = 0; i < 60; i++) begin
      #1 r = {req1_ready, req0_ready};
      if (r != 2'b00) begin
        if (r == 2'b11 || prev != 2'b00) perr++;
        if (n_acc < 3) acc_ids[2-n_acc] = r[1];
        n_acc++;
        if (n_acc == 3) drop = 1'b1;
      end
      if (out_valid) begin
        if (n_out < 3) begin
          out_ids[2-n_out] = out_id;
          outs = {outs[15:0], out_data};
        end
        n_out++;
      end
      prev = r;
      if (n_out == 3) break;
      @(negedge clk);
      if (drop) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (perr !== 0 || n_acc !== 3) begin
      n_fail++; $display("FAIL t4_ready_pulse: got errs=%0d accepts=%0d expected 0/3", perr, n_acc);
    end
    n_checks++;
    if (acc_ids !== 3'b010 || out_ids !== 3'b010) begin
      n_fail++; $display("FAIL t4_order: got acc=%b out=%b expected 010/010", acc_ids, out_ids);
    end
    n_checks++;
    if (outs !== 24'h068006) begin
      n_fail++; $display("FAIL t4_data: got %h expected 068006", outs);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat; logic [11:0] seq; logic [7:0] q; logic qid; logic [1:0] rdy;
    int herr = 0;
    out_ready = 1'b0;
    do_job(1'b0, 8'h81, 3'd1, lat, seq, q, qid, rdy);
    n_checks++;
    if (q !== 8'h02 || qid !== 1'b0 || lat !== 2) begin
      n_fail++; $display("FAIL t5_result: got q=%h id=%b lat=%0d expected 02/0/2", q, qid, lat);
    end
    req1_valid = 1'b1; req1_data = 8'h11; req1_amt = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b1 || out_data !== 8'h02 || out_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
        herr++;
    end
    n_checks++;
    if (herr !== 0) begin
      n_fail++; $display("FAIL t5_hold: got %0d bad cycles expected 0", herr);
    end
    req1_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t5_release: got ov=%b busy=%b expected 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset_midjob();
    int lat; logic [11:0] seq; logic [7:0] q; logic qid; logic [1:0] rdy;
    int vseen = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h3C; req0_amt = 3'd6;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || sh_shift !== 2'd3 || sh_d !== 8'hE0) begin
      n_fail++; $display("FAIL t6_second_wait: got busy=%b sh=%0d d=%h expected 1/3/e0", busy, sh_shift, sh_d);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, out_id, sh_shift, sh_d, busy,
         req0_ready, req1_ready} !== 22'd0) begin
      n_fail++;
      $display("FAIL t6_reset_outputs: got ov=%b od=%h id=%b sh=%0d d=%h busy=%b expected all 0",
               out_valid, out_data, out_id, sh_shift, sh_d, busy);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) vseen++;
    end
    n_checks++;
    if (vseen !== 0) begin
      n_fail++; $display("FAIL t6_no_result: got %0d valid cycles expected 0", vseen);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL t6_grant_after_reset: got %b expected 01", {req1_ready, req0_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    do_job(1'b1, 8'h0F, 3'd4, lat, seq, q, qid, rdy);
    n_checks++;
    if (q !== 8'hF0 || qid !== 1'b1 || lat !== 4 || seq !== 12'h00D) begin
      n_fail++; $display("FAIL t6_next_job: got q=%h id=%b lat=%0d seq=%h expected f0/1/4/00d", q, qid, lat, seq);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_amt = 3'd0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 3'd0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_multipass();
    test_edges();
    test_back_to_back();
    test_backpressure();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
